// File: rtl/prbs_gen.sv
// Parametrised Fibonacci LFSR word generator. OUT_BITS steps are unrolled per word.
// Adds run-time seeding, zero-seed substitution, a valid/ready output and a word counter.

module prbs_step #(
   parameter int               WIDTH = 7,
   parameter logic [WIDTH-1:0] TAPS  = 7'b1001000
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt,
   output logic             fb
);
   assign fb  = ^(cur & TAPS);
   assign nxt = {cur[WIDTH-2:0], fb};
endmodule

module prbs_gen #(
   parameter int               WIDTH    = 7,
   parameter logic [WIDTH-1:0] TAPS     = 7'b1001000,
   parameter logic [WIDTH-1:0] SEED     = 7'b1111111,
   parameter int               OUT_BITS = 8,
   parameter int               CNT_W    = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                load,
   input  logic [WIDTH-1:0]    seed_in,
   output logic [OUT_BITS-1:0] rnd,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                lock_err,
   output logic [CNT_W-1:0]    word_cnt
);

   logic [WIDTH-1:0]    s_q;
   logic [WIDTH-1:0]    s_adv;
   logic [OUT_BITS-1:0] word_nxt;
   logic                seed_zero;
   logic                gen;
   logic                drain;

   // Each step lives in its own generate scope so the unrolled chain has no
   // self-dependent combinational vector.
   for (genvar k = 0; k < OUT_BITS; k++) begin : g_step
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] nxt;
      if (k == 0) begin : g_first
         assign cur = s_q;
      end else begin : g_rest
         assign cur = g_step[k-1].nxt;
      end
      prbs_step #(
         .WIDTH (WIDTH),
         .TAPS  (TAPS)
      ) u_step (
         .cur (cur),
         .nxt (nxt),
         .fb  (word_nxt[k])
      );
   end

   assign s_adv     = g_step[OUT_BITS-1].nxt;
   assign seed_zero = (seed_in == '0);
   assign gen       = enable && (!out_valid || out_ready);
   assign drain     = !enable && out_valid && out_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s_q       <= SEED;
         rnd       <= '0;
         out_valid <= 1'b0;
         lock_err  <= 1'b0;
         word_cnt  <= '0;
      end else begin
         lock_err <= 1'b0;
         if (load) begin
            // a zero seed would freeze the LFSR, so fall back to SEED and flag it
            s_q       <= seed_zero ? SEED : seed_in;
            lock_err  <= seed_zero;
            out_valid <= 1'b0;
            word_cnt  <= '0;
         end else if (gen) begin
            s_q       <= s_adv;
            rnd       <= word_nxt;
            out_valid <= 1'b1;
            word_cnt  <= word_cnt + CNT_W'(1);
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prbs_gen.sv
// Scoreboard bench for prbs_gen: default 802.11 instance plus a 9-bit, 1-bit-per-word instance.
// Stimulus pushes expected accepted words; monitors pop on each accepted handshake.

module tb_prbs_gen;

   typedef struct {
      logic [63:0] rnd;
      logic [15:0] cnt;
   } exp_t;

   logic        clock;
   logic        reset, enable, load, out_ready;
   logic [6:0]  seed_in;
   logic [7:0]  rnd;
   logic        out_valid, lock_err;
   logic [15:0] word_cnt;

   logic        rst2, en2, load2, rdy2;
   logic [8:0]  seed2;
   logic [0:0]  rnd2;
   logic        ov2, lerr2;
   logic [15:0] cnt2;

   int   nvec = 0;
   int   nerr = 0;
   int   zero_hits = 0;
   bit   rec1 = 0, rec2 = 0;
   exp_t q1[$];
   exp_t q2[$];
   bit   bits1[$];
   bit   bits2[$];

   prbs_gen dut1 (
      .clock(clock), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
      .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready), .lock_err(lock_err),
      .word_cnt(word_cnt)
   );

   prbs_gen #(
      .WIDTH(9), .TAPS(9'b100010000), .SEED(9'h1FF), .OUT_BITS(1), .CNT_W(16)
   ) dut2 (
      .clock(clock), .reset(rst2), .enable(en2), .load(load2), .seed_in(seed2),
      .rnd(rnd2), .out_valid(ov2), .out_ready(rdy2), .lock_err(lerr2),
      .word_cnt(cnt2)
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Bit-serial x^7+x^4+1 reference: feedback from state bits 6 and 3.
   task automatic m7_word(inout logic [6:0] m, output logic [7:0] w);
      logic fb;
      w = '0;
      for (int k = 0; k < 8; k++) begin
         fb   = m[6] ^ m[3];
         w[k] = fb;
         m    = {m[5:0], fb};
      end
   endtask

   // Bit-serial x^9+x^5+1 reference: feedback from state bits 8 and 4.
   task automatic m9_bit(inout logic [8:0] m, output logic b);
      b = m[8] ^ m[4];
      m = {m[7:0], b};
   endtask

   task automatic push1(input logic [7:0] w, input int c);
      exp_t e;
      e.rnd = 64'(w);
      e.cnt = 16'(c);
      q1.push_back(e);
   endtask

   task automatic push2(input logic b, input int c);
      exp_t e;
      e.rnd = 64'(b);
      e.cnt = 16'(c);
      q2.push_back(e);
   endtask

   task automatic run1(input int n);
      enable = 1; out_ready = 1;
      repeat (n) tick();
      enable = 0;
      tick();
   endtask

   task automatic run2(input int n);
      en2 = 1; rdy2 = 1;
      repeat (n) tick();
      en2 = 0;
      tick();
   endtask

   // Scoreboard monitors: a word is consumed on the edge after a valid&ready sample.
   always @(negedge clock) begin
      if (reset && out_valid && out_ready && !load) begin
         if (q1.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL dut1_unexpected_word: got %0h expected none", rnd);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("dut1_rnd", 64'(rnd), e.rnd);
            chk("dut1_cnt", 64'(word_cnt), 64'(e.cnt));
         end
         if (rec1) for (int b = 0; b < 8; b++) bits1.push_back(rnd[b]);
      end
      if (rst2 && ov2 && rdy2 && !load2) begin
         if (q2.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL dut2_unexpected_word: got %0h expected none", rnd2);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("dut2_rnd", 64'(rnd2), e.rnd);
            chk("dut2_cnt", 64'(cnt2), 64'(e.cnt));
         end
         if (rec2) bits2.push_back(rnd2[0]);
      end
      if (reset && dut1.s_q == '0) zero_hits++;
      if (rst2 && dut2.s_q == '0) zero_hits++;
   end

   initial begin
      logic [6:0] m7;
      logic [8:0] m9;
      logic [7:0] w;
      logic       b;
      int         perr;

      reset = 0; enable = 0; load = 0; out_ready = 0; seed_in = '0;
      rst2 = 0; en2 = 0; load2 = 0; rdy2 = 0; seed2 = '0;
      #3;
      chk("reset_rnd", 64'(rnd), 64'h0);
      chk("reset_valid", 64'(out_valid), 64'h0);
      chk("reset_lock_err", 64'(lock_err), 64'h0);
      chk("reset_cnt", 64'(word_cnt), 64'h0);
      tick(); tick();
      reset = 1;
      tick();

      // First three words from SEED
      push1(8'h70, 1); push1(8'h4F, 2); push1(8'h93, 3);
      run1(3);

      // Back-pressure after the first word of a fresh sequence
      reset = 0; tick(); reset = 1; tick();
      push1(8'h70, 1); push1(8'h4F, 2);
      enable = 1; out_ready = 0;
      tick();
      repeat (5) begin
         chk("bp_valid", 64'(out_valid), 64'h1);
         chk("bp_rnd", 64'(rnd), 64'h70);
         chk("bp_cnt", 64'(word_cnt), 64'h1);
         tick();
      end
      run1(1);

      // Zero-seed load substitutes SEED and pulses lock_err once
      load = 1; seed_in = 7'h00; enable = 1; out_ready = 1;
      tick();
      load = 0; enable = 0;
      chk("zload_lock_err", 64'(lock_err), 64'h1);
      chk("zload_valid", 64'(out_valid), 64'h0);
      chk("zload_cnt", 64'(word_cnt), 64'h0);
      tick();
      chk("zload_lock_err_clear", 64'(lock_err), 64'h0);
      push1(8'h70, 1);
      run1(1);

      // Mid-stream load drops the pending word
      enable = 1; out_ready = 0;
      tick();
      chk("pend_valid", 64'(out_valid), 64'h1);
      chk("pend_rnd", 64'(rnd), 64'h4F);
      load = 1; seed_in = 7'h7F; out_ready = 1;
      tick();
      load = 0; enable = 0;
      chk("load_valid", 64'(out_valid), 64'h0);
      chk("load_cnt", 64'(word_cnt), 64'h0);
      chk("load_lock_err", 64'(lock_err), 64'h0);
      push1(8'h70, 1);
      run1(1);

      // Long run against the serial model, then period check on the bitstream
      load = 1; seed_in = 7'h7F;
      tick();
      load = 0;
      m7 = 7'h7F;
      for (int i = 0; i < 128; i++) begin
         m7_word(m7, w);
         push1(w, i + 1);
      end
      rec1 = 1;
      run1(128);
      rec1 = 0;
      chk("period7_len", 64'(bits1.size()), 64'd1024);
      perr = 0;
      for (int i = 0; i + 127 < bits1.size(); i++)
         if (bits1[i] != bits1[i+127]) perr++;
      chk("period7", 64'(perr), 64'h0);

      // 9-bit instance, one bit per word
      chk("dut2_reset_valid", 64'(ov2), 64'h0);
      chk("dut2_reset_cnt", 64'(cnt2), 64'h0);
      rst2 = 1;
      tick();
      m9 = 9'h1FF;
      for (int i = 0; i < 1100; i++) begin
         m9_bit(m9, b);
         push2(b, i + 1);
      end
      rec2 = 1;
      run2(1100);
      rec2 = 0;
      perr = 0;
      for (int i = 0; i + 511 < bits2.size(); i++)
         if (bits2[i] != bits2[i+511]) perr++;
      chk("period9_len", 64'(bits2.size()), 64'd1100);
      chk("period9", 64'(perr), 64'h0);

      // Async reset mid-run: the third generated word is still pending when reset hits
      m9_bit(m9, b); push2(b, 1101);
      m9_bit(m9, b); push2(b, 1102);
      en2 = 1; rdy2 = 1;
      tick(); tick(); tick();
      #1 rst2 = 0;
      #1;
      chk("async_rst_valid", 64'(ov2), 64'h0);
      chk("async_rst_cnt", 64'(cnt2), 64'h0);
      en2 = 0;
      tick();
      rst2 = 1;
      tick();
      m9 = 9'h1FF;
      m9_bit(m9, b); push2(b, 1);
      m9_bit(m9, b); push2(b, 2);
      run2(2);

      tick();
      chk("q1_drained", 64'(q1.size()), 64'h0);
      chk("q2_drained", 64'(q2.size()), 64'h0);
      chk("state_never_zero", 64'(zero_hits), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
